// File: rtl/bus_arbiter_if.sv
// Bundles both requester views (F, L) and the shared downstream bus of bus_arbiter.
// The master modport is the arbiter's side; slave is the requesters' and device's side.
interface bus_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  f_start;
  logic [ADDR_WIDTH-1:0] f_address;
  logic                  f_write;
  logic [DATA_WIDTH-1:0] f_write_data;
  logic                  f_available;
  logic                  f_ready;
  logic                  f_response;
  logic [DATA_WIDTH-1:0] f_read_data;

  logic                  l_start;
  logic [ADDR_WIDTH-1:0] l_address;
  logic                  l_write;
  logic [DATA_WIDTH-1:0] l_write_data;
  logic                  l_available;
  logic                  l_ready;
  logic                  l_response;
  logic [DATA_WIDTH-1:0] l_read_data;

  logic                  m_start;
  logic [ADDR_WIDTH-1:0] m_address;
  logic                  m_write;
  logic [DATA_WIDTH-1:0] m_write_data;
  logic                  m_ready;
  logic                  m_response;
  logic [DATA_WIDTH-1:0] m_read_data;

  modport master (
    input  f_start, f_address, f_write, f_write_data,
    output f_available, f_ready, f_response, f_read_data,
    input  l_start, l_address, l_write, l_write_data,
    output l_available, l_ready, l_response, l_read_data,
    output m_start, m_address, m_write, m_write_data,
    input  m_ready, m_response, m_read_data
  );

  modport slave (
    output f_start, f_address, f_write, f_write_data,
    input  f_available, f_ready, f_response, f_read_data,
    output l_start, l_address, l_write, l_write_data,
    input  l_available, l_ready, l_response, l_read_data,
    input  m_start, m_address, m_write, m_write_data,
    output m_ready, m_response, m_read_data
  );
endinterface

// File: rtl/bus_arbiter.sv
// Shares one downstream bus between fetch (F) and load/store (L), with a hung-transfer watchdog.
// Define BUS_ARB_ROUND_ROBIN_EN for two-way round-robin; otherwise fixed priority, L over F.
module bus_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          clock,
  input  logic          reset,
  bus_arbiter_if.master bus_if
);
  typedef enum logic {ST_IDLE, ST_BUSY} state_e;
  typedef enum logic {OWN_F, OWN_L} owner_e;

  state_e                state_q, state_d;
  owner_e                owner_q, owner_d;
  owner_e                winner;
  logic                  issued_q, issued_d;
  logic                  m_start_q, m_start_d;
  logic [ADDR_WIDTH-1:0] m_address_q, m_address_d;
  logic                  m_write_q, m_write_d;
  logic [DATA_WIDTH-1:0] m_write_data_q, m_write_data_d;
  logic                  grant, done, timeout_hit;
  logic                  wd_clear, wd_tick, wd_expired;

  assign grant       = (state_q == ST_IDLE) && bus_if.m_ready && (bus_if.f_start || bus_if.l_start);
  assign done        = (state_q == ST_BUSY) && issued_q && bus_if.m_ready;
  assign timeout_hit = (state_q == ST_BUSY) && issued_q && !bus_if.m_ready && wd_expired;

`ifdef BUS_ARB_ROUND_ROBIN_EN
  owner_e rr_q, rr_d;

  // Pointer names the preferred port on a tie and moves to the loser on every grant.
  always_comb begin
    if (bus_if.f_start && bus_if.l_start) winner = rr_q;
    else                                  winner = bus_if.l_start ? OWN_L : OWN_F;
    rr_d = rr_q;
    if (grant) rr_d = (winner == OWN_F) ? OWN_L : OWN_F;
  end

  always_ff @(posedge clock) begin
    if (reset) rr_q <= OWN_F;
    else       rr_q <= rr_d;
  end
`else
  assign winner = bus_if.l_start ? OWN_L : OWN_F;
`endif

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_wd
      localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
      logic [WD_W-1:0] wd_q, wd_d;

      always_comb begin
        wd_d = wd_q;
        if (wd_clear)     wd_d = '0;
        else if (wd_tick) wd_d = wd_q + WD_W'(1);
      end

      always_ff @(posedge clock) begin
        if (reset) wd_q <= '0;
        else       wd_q <= wd_d;
      end

      assign wd_expired = (wd_q == WD_W'(TIMEOUT_CYCLES));
    end else begin : g_no_wd
      logic unused_wd;
      assign unused_wd  = wd_clear ^ wd_tick;
      assign wd_expired = 1'b0;
    end
  endgenerate

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    issued_d       = issued_q;
    m_start_d      = m_start_q;
    m_address_d    = m_address_q;
    m_write_d      = m_write_q;
    m_write_data_d = m_write_data_q;
    wd_clear       = 1'b0;
    wd_tick        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          state_d   = ST_BUSY;
          owner_d   = winner;
          issued_d  = 1'b0;
          wd_clear  = 1'b1;
          m_start_d = 1'b1;
          if (winner == OWN_L) begin
            m_address_d    = bus_if.l_address;
            m_write_d      = bus_if.l_write;
            m_write_data_d = bus_if.l_write_data;
          end else begin
            m_address_d    = bus_if.f_address;
            m_write_d      = bus_if.f_write;
            m_write_data_d = bus_if.f_write_data;
          end
        end
      end
      ST_BUSY: begin
        // The issue cycle ignores m_ready: the device may still show the previous ready.
        issued_d = 1'b1;
        if (done || timeout_hit) begin
          state_d   = ST_IDLE;
          m_start_d = 1'b0;
        end else begin
          wd_tick = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    bus_if.f_available = 1'b0;
    bus_if.f_ready     = 1'b0;
    bus_if.f_response  = 1'b0;
    bus_if.f_read_data = '0;
    bus_if.l_available = 1'b0;
    bus_if.l_ready     = 1'b0;
    bus_if.l_response  = 1'b0;
    bus_if.l_read_data = '0;
    if (state_q == ST_IDLE) begin
      bus_if.f_available = 1'b1;
      bus_if.l_available = 1'b1;
      bus_if.f_ready     = bus_if.m_ready;
      bus_if.l_ready     = bus_if.m_ready;
    end else if (issued_q) begin
      if (owner_q == OWN_F) begin
        bus_if.f_ready     = bus_if.m_ready | timeout_hit;
        bus_if.f_response  = bus_if.m_response | timeout_hit;
        bus_if.f_read_data = timeout_hit ? '0 : bus_if.m_read_data;
      end else begin
        bus_if.l_ready     = bus_if.m_ready | timeout_hit;
        bus_if.l_response  = bus_if.m_response | timeout_hit;
        bus_if.l_read_data = timeout_hit ? '0 : bus_if.m_read_data;
      end
    end
  end

  assign bus_if.m_start      = m_start_q;
  assign bus_if.m_address    = m_address_q;
  assign bus_if.m_write      = m_write_q;
  assign bus_if.m_write_data = m_write_data_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      owner_q        <= OWN_F;
      issued_q       <= 1'b0;
      m_start_q      <= 1'b0;
      m_address_q    <= '0;
      m_write_q      <= 1'b0;
      m_write_data_q <= '0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      issued_q       <= issued_d;
      m_start_q      <= m_start_d;
      m_address_q    <= m_address_d;
      m_write_q      <= m_write_d;
      m_write_data_q <= m_write_data_d;
    end
  end
endmodule
